// File: rtl/dcsk_symbol_mapper.sv
// DCSK symbol mapper: walks a message word MSB first and emits, per bit, a
// reference half of chaotic samples followed by a replayed (optionally negated) data half.
module dcsk_symbol_mapper #(
   parameter int unsigned MSG_WIDTH    = 8,
   parameter int unsigned SAMPLE_WIDTH = 8,
   parameter int unsigned SF           = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           msg_valid,
   output logic                           msg_ready,
   input  logic [MSG_WIDTH-1:0]           msg_data,
   input  logic signed [SAMPLE_WIDTH-1:0] chaos_in,
   output logic signed [SAMPLE_WIDTH-1:0] tx_sample,
   output logic                           tx_valid,
   output logic                           tx_phase,
   output logic                           sym_start,
   output logic                           done,
   output logic                           busy
);

   localparam int unsigned BW = $clog2(MSG_WIDTH);
   localparam int unsigned CW = $clog2(SF);
   localparam int unsigned SW = SAMPLE_WIDTH;
   localparam logic [BW-1:0] BIT_LAST  = BW'(MSG_WIDTH - 1);
   localparam logic [CW-1:0] CHIP_LAST = CW'(SF - 1);
   localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};
   localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REF  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [MSG_WIDTH-1:0]  r_msg;
   logic [BW-1:0]         r_bit_idx;
   logic [CW-1:0]         r_chip_cnt;
   logic signed [SW-1:0]  r_buf [SF];

   logic signed [SW-1:0]  r_tx_sample;
   logic                  r_tx_valid;
   logic                  r_tx_phase;
   logic                  r_sym_start;
   logic                  r_done;
   logic                  r_busy;
   logic                  r_msg_ready;

   logic                  w_capture;
   logic                  w_chip_last;
   logic                  w_bit_last;
   logic signed [SW-1:0]  w_buf_rd;
   logic signed [SW-1:0]  w_neg;
   logic signed [SW-1:0]  w_tx_sample_d;
   logic                  w_tx_valid_d;
   logic                  w_tx_phase_d;
   logic                  w_sym_start_d;
   logic                  w_done_d;

   assign w_capture   = (r_state == S_IDLE) && msg_valid && r_msg_ready;
   assign w_chip_last = (r_chip_cnt == CHIP_LAST);
   assign w_bit_last  = (r_bit_idx == '0);
   assign w_buf_rd    = r_buf[r_chip_cnt];
   // Saturating negation: the most negative code has no positive twin.
   assign w_neg       = (w_buf_rd == SMIN) ? SMAX : -w_buf_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_capture) w_next_state = S_REF;
         S_REF:  if (w_chip_last) w_next_state = S_DATA;
         S_DATA: if (w_chip_last) w_next_state = w_bit_last ? S_IDLE : S_REF;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_tx_sample_d = r_tx_sample;
      w_tx_valid_d  = 1'b0;
      w_tx_phase_d  = 1'b0;
      w_sym_start_d = 1'b0;
      w_done_d      = 1'b0;
      case (r_state)
         S_REF: begin
            w_tx_sample_d = chaos_in;
            w_tx_valid_d  = 1'b1;
            w_sym_start_d = (r_chip_cnt == '0);
         end
         S_DATA: begin
            w_tx_sample_d = r_msg[r_bit_idx] ? w_buf_rd : w_neg;
            w_tx_valid_d  = 1'b1;
            w_tx_phase_d  = 1'b1;
            w_done_d      = w_chip_last && w_bit_last;
         end
         default: ;
      endcase
   end

   // Message, bit index and chip counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msg      <= '0;
         r_bit_idx  <= '0;
         r_chip_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_capture) begin
               r_msg      <= msg_data;
               r_bit_idx  <= BIT_LAST;
               r_chip_cnt <= '0;
            end
            S_REF: r_chip_cnt <= w_chip_last ? '0 : r_chip_cnt + CW'(1);
            S_DATA: begin
               r_chip_cnt <= w_chip_last ? '0 : r_chip_cnt + CW'(1);
               if (w_chip_last && !w_bit_last) r_bit_idx <= r_bit_idx - BW'(1);
            end
            default: ;
         endcase
      end
   end

   // Reference-half capture buffer; contents need no reset.
   always_ff @(posedge clk) begin
      if (r_state == S_REF) r_buf[r_chip_cnt] <= chaos_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_sample <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_phase  <= 1'b0;
         r_sym_start <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_msg_ready <= 1'b1;
      end else begin
         r_tx_sample <= w_tx_sample_d;
         r_tx_valid  <= w_tx_valid_d;
         r_tx_phase  <= w_tx_phase_d;
         r_sym_start <= w_sym_start_d;
         r_done      <= w_done_d;
         r_busy      <= (w_next_state != S_IDLE);
         r_msg_ready <= (w_next_state == S_IDLE);
      end
   end

   assign tx_sample = r_tx_sample;
   assign tx_valid  = r_tx_valid;
   assign tx_phase  = r_tx_phase;
   assign sym_start = r_sym_start;
   assign done      = r_done;
   assign busy      = r_busy;
   assign msg_ready = r_msg_ready;

endmodule
